// File: rtl/vending_pkg.sv
// vending_pkg: coin encodings, coin values and cash-path states shared across the vending machine
package vending_pkg;
    localparam logic [1:0] COIN_1  = 2'b00;
    localparam logic [1:0] COIN_2  = 2'b01;
    localparam logic [1:0] COIN_5  = 2'b10;
    localparam logic [1:0] COIN_10 = 2'b11;

    typedef enum logic [1:0] {ACCUM, PAID, DRAIN} cash_state_t;

    function automatic logic [3:0] coin_value(input logic [1:0] t);
        return t == COIN_10 ? 4'd10 : t == COIN_5 ? 4'd5 : t == COIN_2 ? 4'd2 : 4'd1;
    endfunction
endpackage

// File: rtl/refund_selector.sv
// refund_selector: largest coin denomination not exceeding the balance
module refund_selector
    import vending_pkg::*;
#(
    parameter int BAL_W = 6
) (
    input  logic [BAL_W-1:0] balance,
    output logic [1:0]       code,
    output logic [BAL_W-1:0] value
);
    always_comb begin
        code  = balance >= BAL_W'(10) ? COIN_10 :
                balance >= BAL_W'(5)  ? COIN_5  :
                balance >= BAL_W'(2)  ? COIN_2  : COIN_1;
        value = BAL_W'(coin_value(code));
    end
endmodule

// File: rtl/cash_accumulator.sv
// cash_accumulator: coin intake, ticket dispatch and change drain for the vending FSM
module cash_accumulator
    import vending_pkg::*;
#(
    parameter int PRICE   = 15,
    parameter int BAL_W   = 6,
    parameter int MAX_BAL = 63
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coin_valid,
    input  logic [1:0]       coin_type,
    input  logic             rst_cash_accum,
    input  logic             en_cash_accum,
    input  logic             block_cash,
    input  logic             en_refund,
    output logic             dispatch_ticket,
    output logic             coin_reject,
    output logic             refund_coin_valid,
    output logic [1:0]       refund_coin_type,
    output logic             refund_done,
    output logic [BAL_W-1:0] balance
);
    localparam int W = BAL_W + 1;

    cash_state_t      state;
    logic [W-1:0]     bal_x, coin_x, sum_x, next_x;
    logic [1:0]       sel_code;
    logic [BAL_W-1:0] sel_val;
    logic             accept, pay;

    refund_selector #(.BAL_W(BAL_W)) u_sel (
        .balance(balance),
        .code   (sel_code),
        .value  (sel_val)
    );

    // Overflow check uses the pre-dispatch balance, so a coin landing on the dispatch edge is judged conservatively
    always_comb begin
        bal_x  = W'(balance);
        coin_x = W'(coin_value(coin_type));
        sum_x  = bal_x + coin_x;
        accept = coin_valid & en_cash_accum & !block_cash & (state == ACCUM) & (sum_x <= W'(MAX_BAL));
        pay    = (state == ACCUM) & (bal_x >= W'(PRICE));
        next_x = (pay ? bal_x - W'(PRICE) : bal_x) + (accept ? coin_x : '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state             <= ACCUM;
            balance           <= '0;
            dispatch_ticket   <= 1'b0;
            coin_reject       <= 1'b0;
            refund_coin_valid <= 1'b0;
            refund_coin_type  <= COIN_1;
            refund_done       <= 1'b0;
        end else if (rst_cash_accum) begin
            state             <= ACCUM;
            balance           <= '0;
            dispatch_ticket   <= 1'b0;
            coin_reject       <= coin_valid;
            refund_coin_valid <= 1'b0;
            refund_done       <= 1'b0;
        end else if (en_refund) begin
            state             <= DRAIN;
            dispatch_ticket   <= 1'b0;
            coin_reject       <= coin_valid;
            refund_coin_valid <= balance != '0;
            refund_done       <= refund_done | ((state == DRAIN) & (balance == '0));
            if (balance != '0) begin
                refund_coin_type <= sel_code;
                balance          <= balance - sel_val;
            end
        end else begin
            dispatch_ticket   <= pay;
            coin_reject       <= coin_valid & !accept;
            refund_coin_valid <= 1'b0;
            balance           <= BAL_W'(next_x);
            if (pay) state <= PAID;
        end
    end
endmodule

// File: tb/tb_cash_accumulator.sv
// tb_cash_accumulator: scoreboard bench for coin intake, dispatch, rejection and change drain
module tb_cash_accumulator;
    import vending_pkg::*;

    typedef struct {
        logic [2:0] kind;
        logic [1:0] rtype;
        logic [5:0] bal;
    } ev_t;

    localparam logic [2:0] K_DISP = 3'b100;
    localparam logic [2:0] K_REJ  = 3'b010;
    localparam logic [2:0] K_REF  = 3'b001;

    logic       clk = 0, rst = 0;
    logic       coin_valid = 0, big_cv = 0;
    logic [1:0] coin_type = COIN_1;
    logic       rst_cash_accum = 0, en_cash_accum = 0, block_cash = 0, en_refund = 0;
    logic       dispatch_ticket, coin_reject, refund_coin_valid, refund_done;
    logic [1:0] refund_coin_type;
    logic [5:0] balance;
    logic       b_disp, b_rej, b_rv, b_done;
    logic [1:0] b_rtype;
    logic [5:0] b_bal;

    ev_t exp_q[$];
    int  tests = 0, fails = 0;

    cash_accumulator u_dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_type(coin_type),
        .rst_cash_accum(rst_cash_accum), .en_cash_accum(en_cash_accum),
        .block_cash(block_cash), .en_refund(en_refund),
        .dispatch_ticket(dispatch_ticket), .coin_reject(coin_reject),
        .refund_coin_valid(refund_coin_valid), .refund_coin_type(refund_coin_type),
        .refund_done(refund_done), .balance(balance)
    );

    // High-price instance: the only way to reach the MAX_BAL ceiling while still in ACCUM
    cash_accumulator #(.PRICE(63), .BAL_W(6), .MAX_BAL(63)) u_big (
        .clk(clk), .rst(rst), .coin_valid(big_cv), .coin_type(coin_type),
        .rst_cash_accum(rst_cash_accum), .en_cash_accum(en_cash_accum),
        .block_cash(block_cash), .en_refund(en_refund),
        .dispatch_ticket(b_disp), .coin_reject(b_rej),
        .refund_coin_valid(b_rv), .refund_coin_type(b_rtype),
        .refund_done(b_done), .balance(b_bal)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dispatch_ticket === 1'b1 || coin_reject === 1'b1 || refund_coin_valid === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event got kind=%b bal=%0d, required no event",
                         {dispatch_ticket, coin_reject, refund_coin_valid}, balance);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if ({dispatch_ticket, coin_reject, refund_coin_valid} !== e.kind || balance !== e.bal ||
                    (e.kind == K_REF && refund_coin_type !== e.rtype)) begin
                    fails++;
                    $display("FAIL event got kind=%b type=%b bal=%0d, required kind=%b type=%b bal=%0d",
                             {dispatch_ticket, coin_reject, refund_coin_valid}, refund_coin_type, balance,
                             e.kind, e.rtype, e.bal);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] k, input logic [1:0] t, input logic [5:0] b);
        ev_t e;
        e.kind = k; e.rtype = t; e.bal = b;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] t);
        coin_valid = 1; coin_type = t;
        idle(1);
        coin_valid = 0;
    endtask

    task automatic bcoin(input logic [1:0] t);
        big_cv = 1; coin_type = t;
        idle(1);
        big_cv = 0;
    endtask

    task automatic clr();
        rst_cash_accum = 1;
        idle(1);
        rst_cash_accum = 0;
    endtask

    initial begin
        idle(3);
        chk("reset_balance", balance, 0);
        chk("reset_pulses", {dispatch_ticket, coin_reject, refund_coin_valid}, 0);
        chk("reset_done", refund_done, 0);
        rst = 1; en_cash_accum = 1;
        idle(1);

        repeat (6) bcoin(COIN_10);
        chk("big_bal_60", b_bal, 60);
        bcoin(COIN_10);
        chk("big_reject_70", b_rej, 1);
        chk("big_bal_hold", b_bal, 60);
        bcoin(COIN_2);
        chk("big_accept_62", {b_rej, b_bal}, 62);
        bcoin(COIN_2);
        chk("big_reject_64", b_rej, 1);
        bcoin(COIN_1);
        chk("big_accept_63", {b_rej, b_bal}, 63);
        idle(1);
        chk("big_dispatch", {b_disp, b_bal}, 64);
        clr();

        coin(COIN_10);
        chk("s1_bal10", balance, 10);
        push(K_DISP, COIN_1, 0);
        coin(COIN_5);
        chk("s1_bal15", balance, 15);
        idle(1);
        chk("s1_bal0", balance, 0);
        push(K_REJ, COIN_1, 0);
        coin(COIN_1);
        idle(2);
        clr();

        coin(COIN_10);
        push(K_DISP, COIN_1, 5);
        coin(COIN_10);
        chk("s2_bal20", balance, 20);
        idle(1);
        chk("s2_bal5", balance, 5);
        en_refund = 1;
        push(K_REF, COIN_5, 0);
        idle(1);
        chk("s2_done_early", refund_done, 0);
        idle(1);
        chk("s2_done", refund_done, 1);
        idle(1);
        chk("s2_done_hold", refund_done, 1);
        en_refund = 0;
        clr();
        chk("s2_done_clear", refund_done, 0);

        coin(COIN_5); coin(COIN_2); coin(COIN_1);
        chk("s3_bal8", balance, 8);
        en_refund = 1;
        push(K_REF, COIN_5, 3); push(K_REF, COIN_2, 1); push(K_REF, COIN_1, 0);
        idle(3);
        chk("s3_done_early", refund_done, 0);
        idle(1);
        chk("s3_done", refund_done, 1);
        en_refund = 0;
        clr();

        block_cash = 1;
        push(K_REJ, COIN_1, 0);
        coin(COIN_5);
        chk("s4_block_bal", balance, 0);
        block_cash = 0; en_cash_accum = 0;
        push(K_REJ, COIN_1, 0);
        coin(COIN_2);
        chk("s4_disabled_bal", balance, 0);
        en_cash_accum = 1;

        coin(COIN_10); coin(COIN_5);
        push(K_DISP, COIN_1, 10);
        coin(COIN_10);
        chk("s5_bal10", balance, 10);
        idle(2);
        chk("s5_bal_hold", balance, 10);
        clr();

        coin(COIN_10); coin(COIN_2); coin(COIN_1);
        chk("s6_bal13", balance, 13);
        en_refund = 1;
        push(K_REF, COIN_10, 3);
        idle(1);
        rst = 0;
        idle(1);
        chk("s6_rst_bal", balance, 0);
        chk("s6_rst_pulses", {refund_coin_valid, refund_done}, 0);
        idle(2);
        rst = 1; en_refund = 0;
        idle(1);

        coin(COIN_10); coin(COIN_2); coin(COIN_1);
        chk("s7_bal13", balance, 13);
        en_refund = 1;
        push(K_REF, COIN_10, 3);
        idle(1);
        rst_cash_accum = 1;
        idle(1);
        chk("s7_clr_bal", balance, 0);
        chk("s7_clr_pulses", {refund_coin_valid, refund_done}, 0);
        idle(2);
        rst_cash_accum = 0; en_refund = 0;
        idle(2);
        chk("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cash_accumulator.md
# cash_accumulator

Coin-handling datapath feeding the vending-machine control FSM. Accepts coins while the FSM is in COIN, keeps the running balance, and raises `dispatch_ticket` once the ticket price is covered. In REFUND it drains the remaining balance as a sequence of coin-dispense pulses for the coin hopper. Its control inputs come directly from the FSM's `rst_cash_accum`, `en_cash_accum`, `block_cash` and `en_refund` outputs.

## Interface
- `PRICE`, 15, ticket price in pesos.
- `BAL_W`, 6, balance register width.
- `MAX_BAL`, 63, highest balance accepted; must be ≤ 2^BAL_W−1 and ≥ PRICE.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `coin_valid` in 1: one-cycle strobe, coin inserted.
- `coin_type` in 2: 00=1, 01=2, 10=5, 11=10 pesos; sampled with `coin_valid`.
- `rst_cash_accum` in 1: FSM clear, level.
- `en_cash_accum` in 1: FSM accumulate enable, level.
- `block_cash` in 1: FSM blocks coin intake, level.
- `en_refund` in 1: FSM refund enable, level.
- `dispatch_ticket` out 1: one-cycle pulse, price covered.
- `coin_reject` out 1: one-cycle pulse, inserted coin returned to the slot.
- `refund_coin_valid` out 1: one-cycle pulse, dispense one coin.
- `refund_coin_type` out 2: denomination of the dispensed coin, same encoding as `coin_type`.
- `refund_done` out 1: level, refund complete with balance 0.
- `balance` out BAL_W: current balance, for the display.

## Operation
- All outputs are registered. On reset (`rst`=0): `balance`=0, state ACCUM, all pulses and `refund_done` are 0.
- Priority per cycle: `rst` > `rst_cash_accum` > `en_refund` > accumulate/dispatch.
- `rst_cash_accum`=1: `balance`←0, state←ACCUM, pulses←0, `refund_done`←0. Any coin in that cycle is rejected.
- States:
  - ACCUM: accepts coins. Goes to PAID on dispatch. Goes to DRAIN when `en_refund`=1.
  - PAID: no dispatch; coins rejected. Goes to DRAIN when `en_refund`=1.
  - DRAIN: dispenses change. Goes to ACCUM only on `rst_cash_accum`.
- Coin acceptance: requires `coin_valid` & `en_cash_accum` & !`block_cash` & state==ACCUM & `balance`+value ≤ `MAX_BAL`.
  - Accepted: `balance`←`balance`+value.
  - Otherwise, when `coin_valid`=1: `coin_reject`←1 and `balance` is unchanged.
- Dispatch: in ACCUM with registered `balance` ≥ `PRICE`: `dispatch_ticket`←1, `balance`←`balance`−`PRICE`(+coin if one is accepted in the same cycle), state←PAID.
  - Fires exactly once per purchase.
- Drain: in DRAIN with `en_refund`=1 and `balance`>0:
  - Select the largest denomination ≤ `balance` (10, 5, 2, 1).
  - `refund_coin_valid`←1, `refund_coin_type`←that coin, `balance`←`balance`−value.
  - One coin per cycle.
- `refund_done`←1 when state==DRAIN, `en_refund`=1 and `balance`==0. It holds until `rst_cash_accum` or reset.
- `en_refund` deasserted in DRAIN pauses draining; the balance is held.
- Arithmetic is unsigned at BAL_W+1 bits internally. `balance` never wraps or goes negative.

## Timing
- Coin sampled at edge N → `balance`/`coin_reject` updated at edge N.
- Balance reaching `PRICE` at edge N → `dispatch_ticket` high during cycle N+1 to N+2, and `balance` reduced at edge N+1.
- FSM reaction: the FSM sees `dispatch_ticket` in the same cycle it is high.
- Refund: `en_refund` rising before edge N → first `refund_coin_valid` at edge N (the state enters DRAIN at that same edge). One coin per cycle after that.
  - `refund_done` is registered one cycle after the last coin.
- Reset or `rst_cash_accum` mid-drain: stops immediately, no further coin pulses.

## Structure
- Shared package `vending_pkg`:
  - coin encodings (`COIN_1`, `COIN_2`, `COIN_5`, `COIN_10`)
  - function `coin_value(type)` returning pesos
  - enum `cash_state_t` {ACCUM, PAID, DRAIN}
- Sub-module `refund_selector`: combinational. Takes `balance` and outputs the largest denomination code ≤ balance plus its value. Reused by future change-making logic.

## Test plan
- Coins 10 then 5 (PRICE=15) → balance 10, 15; `dispatch_ticket` one pulse; balance 0; state PAID.
- Coins 10, 10 → dispatch with balance 5, then `en_refund` → one refund pulse of type 10 (5 pesos), balance 0, `refund_done`=1.
- Coins 5, 2, 1 (balance 8), then `en_refund` (withdraw) → refund pulses of types 10, 01, 00 on consecutive cycles, then `refund_done`.
- Coin rejection:
  - balance 60 + coin 10 → `coin_reject` pulse, balance stays 60.
  - coin with `block_cash`=1 or `en_cash_accum`=0 → `coin_reject`, balance unchanged.
- Coin 10 arriving in the same cycle as a dispatch from balance 15 → balance 10 and a single dispatch pulse.
- Reset during drain (balance 13, after one coin is dispensed):
  - `rst`=0 → all outputs 0 next edge, no further refund pulses.
  - Repeat the drain with `rst_cash_accum` instead → same behaviour.
